mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the 16-bit multi-cycle CPU's memory interface (memread/memwrite/address/writedata/readdata).
- Replaces the zero-wait memory with a word array that has configurable read and write latency.
- Adds a ready/error handshake so the control unit can stall until the access completes.
- Byte-addressed, 16-bit words, so address[0] must be 0.

Parameters:
- ADDR_WIDTH, 8, word-index bits; array depth is 2**ADDR_WIDTH words, indexed by address[ADDR_WIDTH:1].
- READ_LATENCY, 2, clock edges from the accept edge to the ready cycle for reads; legal range 1..15.
- WRITE_LATENCY, 1, same measure for writes; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- memread  in  1  read request; held by the requester until ready.
- memwrite  in  1  write request; held by the requester until ready.
- address  in  16  byte address of the access.
- writedata  in  16  write data.
- readdata  out  16  read result; valid in the ready cycle and held until the next completed read.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while an access is in flight (WAIT or RESP state).
- error  out  1  one-cycle pulse coincident with ready when a request is rejected.

Behaviour:
- Reset (rst_n=0, takes effect immediately without waiting for a clock edge):
  - state=IDLE; readdata=0, ready=0, busy=0, error=0; latency counter=0.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - At a rising edge with memread|memwrite high, the request is accepted.
  - Latched at acceptance: op, address[ADDR_WIDTH:1], writedata.
  - Counter is loaded with LAT-1, where LAT is READ_LATENCY or WRITE_LATENCY.
  - Next state is RESP if LAT=1, else WAIT.
  - Without a request, the block stays in IDLE.
- WAIT: the counter decrements each edge. When the counter reaches 1, the next state is RESP.
- RESP (exactly one cycle):
  - ready=1. error=1 only for a rejected request.
  - Next edge: return to IDLE. Request inputs are ignored during RESP.
- Read completion:
  - readdata is updated on the edge entering RESP, using the array value at that edge.
  - A write to the same word at the same edge cannot occur, since accesses are serialized.
- Write completion: the array word is written on the edge entering RESP. readdata is unchanged.
- Timing: accept at edge E0, ready high in the cycle after edge E0+LAT-1. The counter counts only edges after E0, so ready is high LAT cycles after the acceptance edge's cycle.
- Spacing: minimum spacing between two accept edges is LAT+1 edges (RESP cycle, then IDLE accept).
- Inputs after acceptance: changes to address, writedata or op during WAIT/RESP are ignored, because the values were latched at acceptance.
- Rejection (checked at accept): the request is rejected if both memread and memwrite are high, or if address[0]=1. On rejection:
  - go directly to RESP (latency 1) with ready=1 and error=1;
  - no array write; readdata unchanged.
- Address range: address bits above ADDR_WIDTH are ignored, so accesses alias with wrap-around modulo the array depth.
- busy=1 in WAIT and RESP, 0 in IDLE.
- Reset mid-operation: the in-flight access is abandoned, with no write even if it was pending. No ready pulse. Outputs go to their reset values immediately.

Test Plan:
- Write 0xBEEF to 0x0010 (WRITE_LATENCY=1), then read 0x0010 (READ_LATENCY=2) -> write ready 1 cycle after accept; read ready 2 cycles after accept with readdata=0xBEEF; busy high exactly 1 and 2 cycles respectively.
- Read latency sweep: READ_LATENCY=1,3,7; read a pre-written word -> ready exactly LAT cycles after acceptance, single-cycle pulse, readdata held afterwards.
- Misaligned read of 0x0011, and memread=memwrite=1 at 0x0020 -> ready=error=1 one cycle after accept; readdata and array unchanged (read 0x0020 afterwards returns the old value).
- Wrap: ADDR_WIDTH=8, write 0x1234 to 0x0202 -> reading 0x0002 returns 0x1234.
- Reset mid-write: WRITE_LATENCY=4, assert rst_n=0 two cycles after accept -> no ready pulse; busy/ready/readdata=0 immediately; target word keeps its old value.
- Back-to-back: requester holds memread continuously across 3 reads -> one accept per LAT+1 edges; no request accepted during RESP.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-array memory responder for the 16-bit multi-cycle CPU.
// It accepts one read or write at a time, with separate configurable read and
// write latencies, and signals completion through a one-cycle ready pulse.
// Misaligned or ambiguous requests (both memread and memwrite high) are
// rejected. A rejected request completes after one cycle with error raised and
// has no effect on the array or on readdata.
module mem_responder #(
    parameter int ADDR_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [15:0] address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The counter holds the number of edges still to wait before entering RESP.
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_op_wr;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [15:0]           r_wdata;
    logic [15:0]           r_mem [DEPTH];
    logic [15:0]           r_readdata;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_error;

    logic                  w_req;
    logic                  w_reject;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic [3:0]            w_acc_load;
    logic                  w_done_fast;
    logic                  w_wait_done;
    logic                  w_done;
    logic                  w_done_wr;
    logic [ADDR_WIDTH-1:0] w_done_idx;
    logic [15:0]           w_done_wdata;
    logic                  w_mem_we;
    logic                  w_unused_addr_bits;

    // Address bits above the word index alias onto the array.
    assign w_unused_addr_bits = ^address[15:ADDR_WIDTH+1];

    assign w_req      = memread | memwrite;
    assign w_reject   = (memread & memwrite) | address[0];
    assign w_accept   = rst_n & (r_state == S_IDLE) & w_req;
    assign w_acc_idx  = address[ADDR_WIDTH:1];
    assign w_acc_load = memwrite ? WR_LOAD : RD_LOAD;

    // A legal access completes either on its accept edge (latency 1) or on the
    // last WAIT edge. On the accept edge the live inputs are used directly
    // because the latch registers are only being loaded on that same edge.
    assign w_done_fast  = w_accept & ~w_reject & (w_acc_load == 4'd0);
    assign w_wait_done  = (r_state == S_WAIT) & (r_cnt == 4'd1);
    assign w_done       = w_done_fast | w_wait_done;
    assign w_done_wr    = w_wait_done ? r_op_wr : memwrite;
    assign w_done_idx   = w_wait_done ? r_idx   : w_acc_idx;
    assign w_done_wdata = w_wait_done ? r_wdata : writedata;
    assign w_mem_we     = w_done & w_done_wr;

    // Capture the request at acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_wr <= memwrite;
            r_idx   <= w_acc_idx;
            r_wdata <= writedata;
        end
    end

    // Array write on the edge that enters RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_done_idx] <= w_done_wdata;
        end
    end

    // Control FSM with registered ready/busy/error/readdata outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_readdata <= 16'd0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (w_reject || (w_acc_load == 4'd0)) begin
                            r_state <= S_RESP;
                            r_cnt   <= 4'd0;
                            r_ready <= 1'b1;
                            r_error <= w_reject;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= w_acc_load;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                        r_cnt   <= 4'd0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_done && !w_done_wr) begin
                r_readdata <= r_mem[w_done_idx];
            end
        end
    end

    assign readdata = r_readdata;
    assign ready    = r_ready;
    assign busy     = r_busy;
    assign error    = r_error;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with different latencies share one
// clock and reset. A time-based reference model predicts every output on every
// cycle, and directed accesses pin latency, error and data with literal values.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        mr  [4];
    logic        mw  [4];
    logic [15:0] ad  [4];
    logic [15:0] wd  [4];
    logic [15:0] rd  [4];
    logic        rdy [4];
    logic        bsy [4];
    logic        err [4];

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(2), .WRITE_LATENCY(1)) u0 (
        .clk(clk), .rst_n(rst_n), .memread(mr[0]), .memwrite(mw[0]), .address(ad[0]),
        .writedata(wd[0]), .readdata(rd[0]), .ready(rdy[0]), .busy(bsy[0]), .error(err[0]));
    mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(1), .WRITE_LATENCY(4)) u1 (
        .clk(clk), .rst_n(rst_n), .memread(mr[1]), .memwrite(mw[1]), .address(ad[1]),
        .writedata(wd[1]), .readdata(rd[1]), .ready(rdy[1]), .busy(bsy[1]), .error(err[1]));
    mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(3), .WRITE_LATENCY(1)) u2 (
        .clk(clk), .rst_n(rst_n), .memread(mr[2]), .memwrite(mw[2]), .address(ad[2]),
        .writedata(wd[2]), .readdata(rd[2]), .ready(rdy[2]), .busy(bsy[2]), .error(err[2]));
    mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(7), .WRITE_LATENCY(1)) u3 (
        .clk(clk), .rst_n(rst_n), .memread(mr[3]), .memwrite(mw[3]), .address(ad[3]),
        .writedata(wd[3]), .readdata(rd[3]), .ready(rdy[3]), .busy(bsy[3]), .error(err[3]));

    function automatic int rl_of(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 7;
        endcase
    endfunction

    function automatic int wl_of(input int i);
        return (i == 1) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Each access is described by its accept cycle and the cycle in which it
    // completes (accept + latency - 1); outputs follow from those numbers.
    logic [15:0] m_mem  [4][256];
    bit          m_mval [4][256];
    bit          m_act  [4];
    int          m_due  [4];
    bit          m_rej  [4];
    bit          m_wr   [4];
    logic [7:0]  m_idx  [4];
    logic [15:0] m_wd   [4];
    logic [15:0] m_rd   [4];
    bit          m_rdk  [4];
    int          cyc;

    initial begin
        int lat;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_rd[i] = 16'd0; m_rdk[i] = 1; m_due[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    m_act[i] = 0; m_rd[i] = 16'd0; m_rdk[i] = 1;
                end
            end else begin
                cyc++;
                for (int i = 0; i < 4; i++) begin
                    if (m_act[i] && cyc == m_due[i] + 1) begin
                        m_act[i] = 0;
                    end else if (!m_act[i] && (mr[i] || mw[i])) begin
                        m_rej[i] = (mr[i] && mw[i]) || ad[i][0];
                        lat = m_rej[i] ? 1 : (mw[i] ? wl_of(i) : rl_of(i));
                        m_due[i] = cyc + lat - 1;
                        m_act[i] = 1;
                        m_wr[i]  = mw[i];
                        m_idx[i] = ad[i][8:1];
                        m_wd[i]  = wd[i];
                    end
                    if (m_act[i] && cyc == m_due[i] && !m_rej[i]) begin
                        if (m_wr[i]) begin
                            m_mem[i][m_idx[i]]  = m_wd[i];
                            m_mval[i][m_idx[i]] = 1;
                        end else begin
                            m_rd[i]  = m_mem[i][m_idx[i]];
                            m_rdk[i] = m_mval[i][m_idx[i]];
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    initial begin
        bit e_rdy;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                e_rdy = m_act[i] && (cyc == m_due[i]);
                chk($sformatf("d%0d_ready_c%0d", i, cyc), 32'(rdy[i]), 32'(e_rdy));
                chk($sformatf("d%0d_busy_c%0d", i, cyc), 32'(bsy[i]), 32'(m_act[i]));
                chk($sformatf("d%0d_error_c%0d", i, cyc), 32'(err[i]), 32'(e_rdy && m_rej[i]));
                if (m_rdk[i])
                    chk($sformatf("d%0d_readdata_c%0d", i, cyc), 32'(rd[i]), 32'(m_rd[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic access(input string nm, input int i, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d, input int exp_lat,
                          input logic exp_err, input bit chk_rd, input logic [15:0] exp_rd,
                          input bit scr);
        int k;
        int nb;
        bit got;
        @(negedge clk);
        mr[i] = r; mw[i] = w; ad[i] = a; wd[i] = d;
        @(posedge clk);
        k = 1; nb = 0; got = 0;
        while (!got && k <= 20) begin
            @(negedge clk);
            if (bsy[i]) nb++;
            if (rdy[i]) got = 1;
            else begin
                if (scr) begin ad[i] = ~a; wd[i] = ~d; end
                @(posedge clk);
                k++;
            end
        end
        chk({nm, "_done"}, 32'(got), 32'd1);
        chk({nm, "_lat"}, k, exp_lat);
        chk({nm, "_busy_cycles"}, nb, exp_lat);
        chk({nm, "_error"}, 32'(err[i]), 32'(exp_err));
        if (chk_rd) chk({nm, "_readdata"}, 32'(rd[i]), 32'(exp_rd));
        mr[i] = 0; mw[i] = 0;
    endtask

    task automatic back_to_back();
        int e;
        int nh;
        int hits [3];
        e = 0; nh = 0;
        for (int j = 0; j < 3; j++) hits[j] = 0;
        @(negedge clk);
        mr[0] = 1; ad[0] = 16'h0050;
        while (nh < 3 && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (rdy[0]) begin
                hits[nh] = e;
                chk($sformatf("b2b_readdata_%0d", nh), 32'(rd[0]), 32'h0C0C);
                nh++;
            end
        end
        mr[0] = 0;
        chk("b2b_count", nh, 3);
        chk("b2b_first", hits[0], 2);
        chk("b2b_second", hits[1], 5);
        chk("b2b_third", hits[2], 8);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mr[i] = 0; mw[i] = 0; ad[i] = 16'd0; wd[i] = 16'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_error", 32'(err[0]), 32'd0);
        chk("rst_readdata", 32'(rd[0]), 32'd0);

        // Basic write then read, with inputs scrambled after acceptance
        access("w10", 0, 0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0, 1);
        access("r10", 0, 1, 0, 16'h0010, 16'h0000, 2, 0, 1, 16'hBEEF, 1);

        // Rejections leave readdata and the array alone
        access("w20", 0, 0, 1, 16'h0020, 16'h5A5A, 1, 0, 0, 16'h0, 0);
        access("mis_rd", 0, 1, 0, 16'h0011, 16'h0000, 1, 1, 1, 16'hBEEF, 0);
        access("both", 0, 1, 1, 16'h0020, 16'hFFFF, 1, 1, 1, 16'hBEEF, 0);
        access("mis_wr", 0, 0, 1, 16'h0021, 16'h7777, 1, 1, 1, 16'hBEEF, 0);
        access("r20", 0, 1, 0, 16'h0020, 16'h0000, 2, 0, 1, 16'h5A5A, 0);

        // Wrap-around aliasing
        access("wwrap", 0, 0, 1, 16'h0202, 16'h1234, 1, 0, 0, 16'h0, 0);
        access("rwrap", 0, 1, 0, 16'h0002, 16'h0000, 2, 0, 1, 16'h1234, 0);

        // Read latency sweep over instances with latency 1, 3 and 7
        for (int i = 1; i < 4; i++) begin
            access($sformatf("sw_w%0d", i), i, 0, 1, 16'h0030, 16'hA000 + 16'(i),
                   wl_of(i), 0, 0, 16'h0, 1);
            access($sformatf("sw_r%0d", i), i, 1, 0, 16'h0030, 16'h0000,
                   rl_of(i), 0, 1, 16'hA000 + 16'(i), 1);
            @(negedge clk);
            chk($sformatf("sw_pulse%0d", i), 32'(rdy[i]), 32'd0);
            repeat (3) @(negedge clk);
            chk($sformatf("sw_hold%0d", i), 32'(rd[i]), 32'hA000 + 32'(i));
        end

        // Reset in the middle of a 4-cycle write
        access("rs_w", 1, 0, 1, 16'h0040, 16'h1111, 4, 0, 0, 16'h0, 0);
        access("rs_r", 1, 1, 0, 16'h0040, 16'h0000, 1, 0, 1, 16'h1111, 0);
        @(negedge clk);
        mw[1] = 1; ad[1] = 16'h0040; wd[1] = 16'h2222;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rs_busy_before", 32'(bsy[1]), 32'd1);
        #1;
        rst_n = 1'b0;
        mw[1] = 0;
        #1;
        chk("rs_busy_now", 32'(bsy[1]), 32'd0);
        chk("rs_ready_now", 32'(rdy[1]), 32'd0);
        chk("rs_readdata_now", 32'(rd[1]), 32'd0);
        chk("rs_readdata_d0", 32'(rd[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access("rs_after", 1, 1, 0, 16'h0040, 16'h0000, 1, 0, 1, 16'h1111, 0);

        // Requester holding memread across three reads
        access("b2b_w", 0, 0, 1, 16'h0050, 16'h0C0C, 1, 0, 0, 16'h0, 0);
        back_to_back();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
